uart_dev_bridge: RTL and testbench
==================================

UART_DEV_BRIDGE -- requirements
Module: uart_dev_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 2500000, inter-byte receive timeout in clk cycles (100 ms at 25 MHz).
REQ-002 SHALL have port clk  input  1  system clock (clkMain domain, 25 MHz); all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port rxdReady_i  input  1  one-cycle pulse, byte received from async_receiver.
REQ-005 SHALL have port rxdData_i  input  8  received byte, valid when rxdReady_i=1.
REQ-006 SHALL have port txdBusy_i  input  1  async_transmitter busy.
REQ-007 SHALL have port txdStart_o  output  1  one-cycle start pulse to transmitter.
REQ-008 SHALL have port txdData_o  output  8  byte to transmit, held stable from the start pulse until the next start pulse.
REQ-009 SHALL have port devEnable_o  output  1  device-bus request.
REQ-010 SHALL have port devWrite_o  output  1  1=write, 0=read.
REQ-011 SHALL have port devPhysicalAddr_o  output  32  bus address.
REQ-012 SHALL have port devDataSave_o  output  32  write data.
REQ-013 SHALL have port devByteSelect_o  output  4  byte enables.
REQ-014 SHALL have port devDataLoad_i  input  32  read data, valid in the completion cycle.
REQ-015 SHALL have port devBusy_i  input  1  responder busy, combinational from the responder.
REQ-016 SHALL have port active_o  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, ADDR, DATA, BUS, TX, TX_GAP.
REQ-018 SHALL, in IDLE, treat received byte 0x52 ('R') as a read command and 0x57 ('W') as a write command, go to ADDR, and clear the byte counter.
REQ-019 SHALL ignore any other byte received in IDLE and stay in IDLE.
REQ-020 SHALL, in ADDR, shift 4 received bytes MSB-first into the address register; after the 4th byte go to DATA for a write or BUS for a read.
REQ-021 SHALL, in DATA, shift 4 received bytes MSB-first into the write-data register; after the 4th byte go to BUS.
REQ-022 SHALL, in ADDR and DATA, reload the timeout counter to TIMEOUT_CYCLES on each received byte.
REQ-023 SHALL, in ADDR and DATA, return to IDLE with no bus or UART activity when the timeout counter reaches 0.
REQ-024 SHALL, in BUS, drive devEnable_o=1, devByteSelect_o=4'b1111, and the full 32-bit address unmodified (no alignment forcing).
REQ-025 SHALL hold devWrite_o, devPhysicalAddr_o and devDataSave_o constant for the whole BUS state.
REQ-026 SHALL complete the bus transaction on the rising edge where devEnable_o=1 and devBusy_i=0; for a read, capture devDataLoad_i into the response shift register on that edge.
REQ-027 SHALL drop devEnable_o in the cycle after completion; minimum devEnable_o high time is 1 cycle when devBusy_i=0.
REQ-028 SHALL have no bus timeout: BUS waits indefinitely while devBusy_i=1.
REQ-029 SHALL, after completion, go to TX: a read sends 4 bytes of captured data MSB-first; a write sends the single byte 0x4B ('K').
REQ-030 SHALL, in TX, pulse txdStart_o for exactly 1 cycle with txdData_o valid, only in a cycle where txdBusy_i=0, then go to TX_GAP.
REQ-031 SHALL hold TX_GAP for exactly 1 cycle, ignoring txdBusy_i, then go to TX if bytes remain, else to IDLE.
REQ-032 SHALL discard rxdReady_i pulses arriving in BUS, TX or TX_GAP.
REQ-033 SHALL never assert devEnable_o and txdStart_o in the same cycle.
REQ-034 SHALL keep devWrite_o=0 and devByteSelect_o=0 outside BUS.

Reset
REQ-035 SHALL, on rst_n=0, immediately force state=IDLE and all outputs to 0: txdStart_o, txdData_o, devEnable_o, devWrite_o, devPhysicalAddr_o, devDataSave_o, devByteSelect_o, active_o.
REQ-036 SHALL, on rst_n=0, clear the byte counter, timeout counter and shift registers.
REQ-037 SHALL abort any bus transaction or UART frame in progress when reset is asserted mid-operation, with devEnable_o falling without waiting for a clock edge.
REQ-038 SHALL, after release, respond only to a new command byte.

Verification
REQ-039 SHALL cover: RX 57 80 00 00 10 DE AD BE EF, devBusy_i=0 -> one bus cycle with devWrite_o=1, addr 0x80000010, data 0xDEADBEEF, be 1111; then TX 0x4B.
REQ-040 SHALL cover: RX 52 BF C0 00 00, responder returns 0x3C08BFC0 with devBusy_i high for 5 cycles -> devEnable_o high for 6 cycles; then TX 3C 08 BF C0.
REQ-041 SHALL cover: RX 57 00 00, then silence for TIMEOUT_CYCLES (reduced to 100 in the bench) -> return to IDLE, no devEnable_o, no txdStart_o; a following 52 frame works normally.
REQ-042 SHALL cover: RX 0x41 in IDLE -> stays IDLE, active_o=0; bytes injected during TX -> ignored, response unchanged.
REQ-043 SHALL cover: txdBusy_i held high for 1000 cycles during TX -> no start pulse until it falls; exactly 4 pulses per read.
REQ-044 SHALL cover: rst_n pulled low while devEnable_o=1 and devBusy_i=1 -> devEnable_o=0 asynchronously, all outputs 0, active_o=0.

Source files
------------

// File: rtl/uart_dev_bridge.sv
// uart_dev_bridge
//   Turns framed UART commands into single device-bus transactions.
//   Read frame  : 'R' A3 A2 A1 A0           -> response D3 D2 D1 D0
//   Write frame : 'W' A3 A2 A1 A0 D3 D2 D1 D0 -> response 'K'
//   Multi-byte fields are sent MSB-first. If the gap between two frame bytes
//   exceeds TIMEOUT_CYCLES, the partial frame is dropped without bus or UART
//   activity.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   rxdReady_i/Data_i   one-cycle strobe and byte from the UART receiver
//   txdBusy_i           UART transmitter busy
//   txdStart_o/Data_o   one-cycle start strobe and byte to the transmitter
//   devEnable_o ...     device-bus request, direction, address, data, enables
//   devDataLoad_i       read data, valid in the completion cycle
//   devBusy_i           responder stall (may depend combinationally on the
//                       request)
//   active_o            high whenever a command is being handled
module uart_dev_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxdReady_i,
  input  logic [7:0]  rxdData_i,
  input  logic        txdBusy_i,
  output logic        txdStart_o,
  output logic [7:0]  txdData_o,
  output logic        devEnable_o,
  output logic        devWrite_o,
  output logic [31:0] devPhysicalAddr_o,
  output logic [31:0] devDataSave_o,
  output logic [3:0]  devByteSelect_o,
  input  logic [31:0] devDataLoad_i,
  input  logic        devBusy_i,
  output logic        active_o
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_RELOAD = TIMEOUT_CYCLES[TO_W-1:0];
  localparam logic [TO_W-1:0] TO_ONE    = 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_BUS    = 3'd3;
  localparam logic [2:0] S_TX     = 3'd4;
  localparam logic [2:0] S_TX_GAP = 3'd5;

  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] ACK_BYTE  = 8'h4B;

  logic [2:0]      state;
  logic            is_write;
  logic [1:0]      byte_cnt;
  logic [TO_W-1:0] timeout_cnt;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic [31:0]     resp;      // response bytes still to send, next in [31:24]
  logic [2:0]      tx_left;   // response bytes not yet started
  logic [7:0]      txd_data;  // last byte handed to the transmitter
  logic            tx_fire;

  assign tx_fire = (state == S_TX) && !txdBusy_i;

  // Everything visible to the bus and UART is decoded from state, so an
  // asynchronous reset removes a pending request without waiting for clk.
  assign active_o          = (state != S_IDLE);
  assign devEnable_o       = (state == S_BUS);
  assign devWrite_o        = devEnable_o && is_write;
  assign devByteSelect_o   = {4{devEnable_o}};
  assign devPhysicalAddr_o = addr;
  assign devDataSave_o     = wdata;
  assign txdStart_o        = tx_fire;
  // Present the new byte in the start cycle, then hold it from the register
  // until the following start.
  assign txdData_o         = tx_fire ? resp[31:24] : txd_data;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      is_write    <= 1'b0;
      byte_cnt    <= '0;
      timeout_cnt <= '0;
      addr        <= '0;
      wdata       <= '0;
      resp        <= '0;
      tx_left     <= '0;
      txd_data    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rxdReady_i && (rxdData_i == CMD_READ || rxdData_i == CMD_WRITE)) begin
            is_write    <= (rxdData_i == CMD_WRITE);
            byte_cnt    <= '0;
            timeout_cnt <= TO_RELOAD;
            state       <= S_ADDR;
          end
        end

        S_ADDR, S_DATA: begin
          if (rxdReady_i) begin
            if (state == S_ADDR) addr  <= {addr[23:0], rxdData_i};
            else                 wdata <= {wdata[23:0], rxdData_i};
            timeout_cnt <= TO_RELOAD;
            byte_cnt    <= byte_cnt + 2'd1;  // wraps to 0 after the 4th byte
            if (byte_cnt == 2'd3) begin
              state <= (state == S_ADDR && is_write) ? S_DATA : S_BUS;
            end
          end else if (timeout_cnt == '0) begin
            state <= S_IDLE;
          end else begin
            timeout_cnt <= timeout_cnt - TO_ONE;
          end
        end

        S_BUS: begin
          if (!devBusy_i) begin
            resp    <= is_write ? {ACK_BYTE, 24'h0} : devDataLoad_i;
            tx_left <= is_write ? 3'd1 : 3'd4;
            state   <= S_TX;
          end
        end

        S_TX: begin
          if (tx_fire) begin
            txd_data <= resp[31:24];
            resp     <= {resp[23:0], 8'h00};
            tx_left  <= tx_left - 3'd1;
            state    <= S_TX_GAP;
          end
        end

        // One dead cycle lets the transmitter raise busy for the byte just
        // started before TX looks at it again.
        S_TX_GAP: state <= (tx_left != 3'd0) ? S_TX : S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_dev_bridge.sv
module tb_uart_dev_bridge;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd_ready = 1'b0;
  logic [7:0]  rxd_data = 8'h00;
  logic        txd_busy;
  logic        txd_start;
  logic [7:0]  txd_data;
  logic        dev_en;
  logic        dev_write;
  logic [31:0] dev_addr;
  logic [31:0] dev_wdata;
  logic [3:0]  dev_be;
  logic [31:0] dev_load;
  logic        dev_busy;
  logic        active;

  uart_dev_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rxdReady_i        (rxd_ready),
    .rxdData_i         (rxd_data),
    .txdBusy_i         (txd_busy),
    .txdStart_o        (txd_start),
    .txdData_o         (txd_data),
    .devEnable_o       (dev_en),
    .devWrite_o        (dev_write),
    .devPhysicalAddr_o (dev_addr),
    .devDataSave_o     (dev_wdata),
    .devByteSelect_o   (dev_be),
    .devDataLoad_i     (dev_load),
    .devBusy_i         (dev_busy),
    .active_o          (active)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- responder model: stalls busy_cycles cycles per request
  int          busy_cycles = 0;
  int          en_cnt = 0;
  logic [31:0] rd_data = 32'h0;
  assign dev_load = rd_data;
  assign dev_busy = dev_en && (en_cnt < busy_cycles);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      en_cnt <= 0;
    else if (dev_en) en_cnt <= en_cnt + 1;
    else             en_cnt <= 0;
  end

  // ---------------- transmitter model: busy for tx_len cycles after a start
  int   tx_len = 4;
  int   tx_cnt = 0;
  logic tx_hold = 1'b0;
  assign txd_busy = tx_hold || (tx_cnt > 0);
  always @(posedge clk) begin
    if (txd_start)       tx_cnt <= tx_len;
    else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
  end

  // ---------------- observers, sampled on the falling edge
  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } bus_t;

  bus_t        bus_q[$];
  logic [7:0]  tx_q[$];
  bus_t        bus_first;
  int          en_run = 0;
  int          last_en_len = 0;
  logic [7:0]  last_tx = 8'h00;
  bit          have_tx = 1'b0;
  int          viol_busy = 0, viol_both = 0, viol_idle = 0, viol_hold = 0, viol_stable = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (dev_en) begin
        en_run++;
        if (en_run == 1) bus_first = '{dev_write, dev_addr, dev_wdata, dev_be};
        else if (bus_first !== bus_t'({dev_write, dev_addr, dev_wdata, dev_be})) viol_hold++;
        if (!dev_busy) begin
          bus_q.push_back('{dev_write, dev_addr, dev_wdata, dev_be});
          last_en_len = en_run;
          en_run = 0;
        end
      end else if (dev_write || dev_be != 4'h0) begin
        viol_idle++;
      end
      if (txd_start) begin
        tx_q.push_back(txd_data);
        if (txd_busy) viol_busy++;
        last_tx = txd_data;
        have_tx = 1'b1;
      end else if (have_tx && txd_data !== last_tx) begin
        viol_stable++;
      end
      if (dev_en && txd_start) viol_both++;
    end
  end

  // ---------------- helpers
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk);
    rxd_ready = 1'b1;
    rxd_data  = b;
    @(negedge clk);
    rxd_ready = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000 && active; i++) @(negedge clk);
    check({tag, "_idle"}, 32'(active), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_active"}, 32'(active), 32'd0);
    check({tag, "_en"},     32'(dev_en), 32'd0);
    check({tag, "_start"},  32'(txd_start), 32'd0);
    check({tag, "_txd"},    32'(txd_data), 32'd0);
    check({tag, "_write"},  32'(dev_write), 32'd0);
    check({tag, "_addr"},   dev_addr, 32'd0);
    check({tag, "_wdata"},  dev_wdata, 32'd0);
    check({tag, "_be"},     32'(dev_be), 32'd0);
  endtask

  // mode 0: plain; 1: inject RX bytes during the response; 2: hold txd busy 1000 cycles
  task automatic run_txn(input string tag, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input int bc, input int txl, input int mode);
    logic [7:0] exp_tx[$];
    busy_cycles = bc;
    tx_len      = txl;
    rd_data     = wr ? ~d : d;
    bus_q.delete();
    tx_q.delete();
    if (mode == 2) tx_hold = 1'b1;
    rx_byte(wr ? 8'h57 : 8'h52);
    for (int i = 0; i < 4; i++) rx_byte(a[31-8*i -: 8]);
    if (wr) for (int i = 0; i < 4; i++) rx_byte(d[31-8*i -: 8]);
    if (mode == 1) begin
      for (int i = 0; i < 500 && tx_q.size() == 0; i++) @(negedge clk);
      check({tag, "_first_tx"}, 32'(tx_q.size() > 0), 32'd1);
      rx_byte(8'h57);
      rx_byte(8'h41);
      rx_byte(8'h52);
    end
    if (mode == 2) begin
      repeat (1000) @(negedge clk);
      check({tag, "_no_start_while_busy"}, 32'(tx_q.size()), 32'd0);
      check({tag, "_still_active"}, 32'(active), 32'd1);
      @(posedge clk);
      #1 tx_hold = 1'b0;
    end
    wait_idle(tag);

    check({tag, "_bus_count"}, 32'(bus_q.size()), 32'd1);
    if (bus_q.size() > 0) begin
      check({tag, "_bus_write"}, 32'(bus_q[0].w), 32'(wr));
      check({tag, "_bus_addr"},  bus_q[0].a, a);
      if (wr) check({tag, "_bus_data"}, bus_q[0].d, d);
      check({tag, "_bus_be"},    32'(bus_q[0].be), 32'hF);
      check({tag, "_en_len"},    32'(last_en_len), 32'(bc + 1));
    end

    if (wr) exp_tx.push_back(8'h4B);
    else for (int i = 0; i < 4; i++) exp_tx.push_back(d[31-8*i -: 8]);
    check({tag, "_tx_count"}, 32'(tx_q.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
      check($sformatf("%s_tx%0d", tag, i), 32'(tx_q[i]), 32'(exp_tx[i]));

    repeat (3) @(negedge clk);
    check({tag, "_rest_idle"}, 32'(active), 32'd0);
  endtask

  // ---------------- directed sequence
  initial begin
    #2;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_txn("wr_basic", 1'b1, 32'h80000010, 32'hDEADBEEF, 0, 4, 0);
    run_txn("rd_stall", 1'b0, 32'hBFC00000, 32'h3C08BFC0, 5, 6, 0);

    for (int k = 0; k < 8; k++)
      run_txn($sformatf("rand%0d", k), 1'($urandom_range(0, 1)), $urandom, $urandom,
              $urandom_range(0, 4), $urandom_range(1, 12), 0);

    // partial frame followed by silence
    bus_q.delete();
    tx_q.delete();
    rx_byte(8'h57);
    rx_byte(8'h00);
    rx_byte(8'h00);
    repeat (80) @(negedge clk);
    check("timeout_before", 32'(active), 32'd1);
    repeat (40) @(negedge clk);
    check("timeout_after", 32'(active), 32'd0);
    check("timeout_no_bus", 32'(bus_q.size()), 32'd0);
    check("timeout_no_tx", 32'(tx_q.size()), 32'd0);
    run_txn("after_timeout", 1'b0, $urandom, $urandom, 1, 3, 0);

    // unknown command byte
    rx_byte(8'h41);
    repeat (5) @(negedge clk);
    check("ignore_41", 32'(active), 32'd0);

    run_txn("inject", 1'b0, $urandom, 32'hA5C3_1E77, 0, 20, 1);
    run_txn("tx_hold", 1'b0, $urandom, $urandom, 2, 5, 2);

    // reset in the middle of a stalled bus request
    busy_cycles = 1000000;
    rx_byte(8'h52);
    for (int i = 0; i < 4; i++) rx_byte(8'h11);
    for (int i = 0; i < 200 && !dev_en; i++) @(negedge clk);
    check("rst_en_seen", 32'(dev_en), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    repeat (2) @(negedge clk);
    bus_q.delete();
    tx_q.delete();
    en_run      = 0;
    have_tx     = 1'b0;
    busy_cycles = 0;
    rst_n = 1'b1;

    // leftover frame bytes must not start a command
    rx_byte(8'h00);
    rx_byte(8'h11);
    rx_byte(8'h4B);
    repeat (5) @(negedge clk);
    check("post_reset_idle", 32'(active), 32'd0);
    run_txn("post_reset", 1'b1, $urandom, $urandom, 3, 2, 0);

    check("start_while_busy", 32'(viol_busy), 32'd0);
    check("en_and_start", 32'(viol_both), 32'd0);
    check("write_be_outside_bus", 32'(viol_idle), 32'd0);
    check("bus_fields_stable", 32'(viol_hold), 32'd0);
    check("txd_data_stable", 32'(viol_stable), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
